// File: rtl/cdb_writeback.sv
// Result slot per execution unit, round-robin winner broadcast on a registered CDB; accept at edge T -> CDB valid after T+1.
// ex_ready drops while a slot is occupied and not granted this cycle, and during flush.
module cdb_writeback #(
  parameter int N_UNITS = 4,
  parameter int DATA_W  = 16,
  parameter int ROB_W   = 3,
  parameter int RD_W    = 4,
  parameter int RSI_W   = 2
) (
  input  logic                      clk2,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [N_UNITS-1:0]        ex_valid,
  output logic [N_UNITS-1:0]        ex_ready,
  input  logic [N_UNITS*DATA_W-1:0] ex_data,
  input  logic [N_UNITS*ROB_W-1:0]  ex_rob,
  input  logic [N_UNITS*RD_W-1:0]   ex_rd,
  input  logic [N_UNITS*RSI_W-1:0]  ex_rsindex,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [ROB_W-1:0]          cdb_rob,
  output logic [RD_W-1:0]           cdb_rd,
  output logic [RSI_W-1:0]          cdb_rsindex,
  output logic [1:0]                cdb_unit,
  output logic [N_UNITS-1:0]        ex_free,
  output logic [2:0]                pending_cnt
);

  localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
    logic [RD_W-1:0]   rd;
    logic [RSI_W-1:0]  rsindex;
  } res_t;

  res_t               slot   [N_UNITS];
  res_t               ex_res [N_UNITS];
  res_t               win_res;
  logic [N_UNITS-1:0] slot_valid;
  logic [N_UNITS-1:0] slot_valid_nxt;
  logic [N_UNITS-1:0] grant;
  logic [N_UNITS-1:0] load;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [2:0]         cnt_nxt;

  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      ex_res[i].data    = ex_data[i*DATA_W +: DATA_W];
      ex_res[i].rob     = ex_rob[i*ROB_W +: ROB_W];
      ex_res[i].rd      = ex_rd[i*RD_W +: RD_W];
      ex_res[i].rsindex = ex_rsindex[i*RSI_W +: RSI_W];
    end
  end

  // Search upward from rr_ptr with wrap; first occupied slot wins.
  always_comb begin
    int idx;
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_UNITS; k++) begin
      idx = (int'(rr_ptr) + k) % N_UNITS;
      if (!win_found && slot_valid[idx]) begin
        win_found  = 1'b1;
        win_idx    = PTR_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign win_res  = slot[win_idx];
  assign ex_ready = {N_UNITS{~flush}} & (~slot_valid | grant);
  assign load     = ex_valid & ex_ready;

  // A granted slot refilled on the same edge stays occupied.
  always_comb begin
    slot_valid_nxt = flush ? '0 : ((slot_valid & ~grant) | load);
    cnt_nxt        = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      cnt_nxt = cnt_nxt + 3'(slot_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      slot_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_data    <= '0;
      cdb_rob     <= '0;
      cdb_rd      <= '0;
      cdb_rsindex <= '0;
      cdb_unit    <= '0;
      ex_free     <= '0;
      pending_cnt <= '0;
    end else begin
      slot_valid  <= slot_valid_nxt;
      pending_cnt <= cnt_nxt;
      if (!flush && win_found) begin
        cdb_valid   <= 1'b1;
        cdb_data    <= win_res.data;
        cdb_rob     <= win_res.rob;
        cdb_rd      <= win_res.rd;
        cdb_rsindex <= win_res.rsindex;
        cdb_unit    <= 2'(win_idx);
        ex_free     <= grant;
        rr_ptr      <= (win_idx == PTR_W'(N_UNITS-1)) ? '0 : win_idx + 1'b1;
      end else begin
        cdb_valid <= 1'b0;
        ex_free   <= '0;
      end
    end
  end

  // Payload needs no reset; it is only observed behind slot_valid.
  always_ff @(posedge clk2) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (load[i]) slot[i] <= ex_res[i];
    end
  end

endmodule

// File: tb/tb_cdb_writeback.sv
// Randomized + directed bench for cdb_writeback with a transaction-level reference model and a scoreboard.
module tb_cdb_writeback;
  localparam int N = 4, DW = 16, RW = 3, DR = 4, SW = 2;

  logic clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  logic          rst, flush;
  logic [N-1:0]  ex_valid, ex_ready, ex_free;
  logic [N*DW-1:0] ex_data;
  logic [N*RW-1:0] ex_rob;
  logic [N*DR-1:0] ex_rd;
  logic [N*SW-1:0] ex_rsindex;
  logic          cdb_valid;
  logic [DW-1:0] cdb_data;
  logic [RW-1:0] cdb_rob;
  logic [DR-1:0] cdb_rd;
  logic [SW-1:0] cdb_rsindex;
  logic [1:0]    cdb_unit;
  logic [2:0]    pending_cnt;

  cdb_writeback dut (
    .clk2(clk2), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data(ex_data), .ex_rob(ex_rob),
    .ex_rd(ex_rd), .ex_rsindex(ex_rsindex),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob(cdb_rob), .cdb_rd(cdb_rd),
    .cdb_rsindex(cdb_rsindex), .cdb_unit(cdb_unit), .ex_free(ex_free), .pending_cnt(pending_cnt)
  );

  typedef struct {
    bit          vld;
    logic [15:0] data;
    logic [2:0]  rob;
    logic [3:0]  rd;
    logic [1:0]  rsi;
    logic [1:0]  unit;
    logic [3:0]  free;
    logic [2:0]  cnt;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0, n_fail = 0;

  // Reference model: one held result per unit plus a rotating priority start.
  bit          m_vld [N];
  logic [15:0] m_data[N];
  logic [2:0]  m_rob [N];
  logic [3:0]  m_rd  [N];
  logic [1:0]  m_rsi [N];
  int          m_ptr;
  exp_t        m_last;

  // Unit side: a result is presented until accepted.
  bit          u_on  [N];
  logic [15:0] u_data[N];
  logic [2:0]  u_rob [N];
  logic [3:0]  u_rd  [N];
  logic [1:0]  u_rsi [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic present(input int i, input logic [15:0] d, input logic [2:0] rb,
                         input logic [3:0] r, input logic [1:0] s);
    u_on[i] = 1'b1; u_data[i] = d; u_rob[i] = rb; u_rd[i] = r; u_rsi[i] = s;
  endtask

  task automatic cycle(input bit r, input bit f);
    bit   rdy[N];
    bit   acc[N];
    int   w;
    exp_t e;
    rst = r;
    flush = f;
    for (int i = 0; i < N; i++) begin
      ex_valid[i]            = u_on[i];
      ex_data[i*DW +: DW]    = u_data[i];
      ex_rob[i*RW +: RW]     = u_rob[i];
      ex_rd[i*DR +: DR]      = u_rd[i];
      ex_rsindex[i*SW +: SW] = u_rsi[i];
      acc[i] = 1'b0;
    end
    #3;
    e = m_last;
    if (r) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      m_ptr = 0;
      e.vld = 0; e.data = '0; e.rob = '0; e.rd = '0; e.rsi = '0; e.unit = '0;
      e.free = '0; e.cnt = '0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && m_vld[j]) w = j;
      end
      for (int i = 0; i < N; i++) begin
        rdy[i] = !f && (!m_vld[i] || i == w);
        check($sformatf("ex_ready[%0d]", i), 32'(ex_ready[i]), 32'(rdy[i]));
      end
      if (f) begin
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        e.vld = 0; e.free = '0;
      end else begin
        if (w >= 0) begin
          e.vld = 1; e.data = m_data[w]; e.rob = m_rob[w]; e.rd = m_rd[w]; e.rsi = m_rsi[w];
          e.unit = 2'(w); e.free = 4'(1 << w);
          m_vld[w] = 1'b0;
          m_ptr = (w + 1) % N;
        end else begin
          e.vld = 0; e.free = '0;
        end
        for (int i = 0; i < N; i++) begin
          if (u_on[i] && rdy[i]) begin
            m_vld[i] = 1'b1; m_data[i] = u_data[i]; m_rob[i] = u_rob[i];
            m_rd[i] = u_rd[i]; m_rsi[i] = u_rsi[i]; acc[i] = 1'b1;
          end
        end
      end
      e.cnt = '0;
      for (int i = 0; i < N; i++) e.cnt = e.cnt + 3'(m_vld[i]);
    end
    m_last = e;
    expq.push_back(e);
    for (int i = 0; i < N; i++) if (acc[i]) u_on[i] = 1'b0;
    @(posedge clk2);
    #1;
  endtask

  // Monitor: one expected CDB state per clock edge.
  always @(posedge clk2) begin
    exp_t e;
    #3;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("cdb_valid",   32'(cdb_valid),   32'(e.vld));
      check("cdb_data",    32'(cdb_data),    32'(e.data));
      check("cdb_rob",     32'(cdb_rob),     32'(e.rob));
      check("cdb_rd",      32'(cdb_rd),      32'(e.rd));
      check("cdb_rsindex", 32'(cdb_rsindex), 32'(e.rsi));
      check("cdb_unit",    32'(cdb_unit),    32'(e.unit));
      check("ex_free",     32'(ex_free),     32'(e.free));
      check("pending_cnt", 32'(pending_cnt), 32'(e.cnt));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = '0;
    ex_data = '0; ex_rob = '0; ex_rd = '0; ex_rsindex = '0;
    for (int i = 0; i < N; i++) begin
      u_on[i] = 1'b0; u_data[i] = '0; u_rob[i] = '0; u_rd[i] = '0; u_rsi[i] = '0;
    end

    // Reset, then idle.
    cycle(1, 0); cycle(1, 0); cycle(0, 0);

    // Single result through unit 2.
    present(2, 16'h0015, 3'd3, 4'h5, 2'd1);
    repeat (4) cycle(0, 0);

    // Four-way contention from a fresh pointer.
    cycle(1, 0);
    present(0, 16'h0010, 3'd0, 4'h1, 2'd0);
    present(1, 16'h0020, 3'd1, 4'h2, 2'd1);
    present(2, 16'h0030, 3'd2, 4'h3, 2'd2);
    present(3, 16'h0040, 3'd3, 4'h4, 2'd3);
    repeat (6) cycle(0, 0);

    // Wrap: grant unit 2, then units 3 and 0 are pending.
    present(2, 16'h0222, 3'd5, 4'h6, 2'd2);
    cycle(0, 0);
    present(0, 16'h0a00, 3'd6, 4'h7, 2'd0);
    present(3, 16'h0d00, 3'd7, 4'h8, 2'd3);
    repeat (5) cycle(0, 0);

    // Back-pressure on unit 0 while unit 1 wins.
    present(0, 16'h1111, 3'd1, 4'h9, 2'd1);
    present(1, 16'h2222, 3'd2, 4'ha, 2'd2);
    cycle(0, 0);
    present(0, 16'h3333, 3'd3, 4'hb, 2'd3);
    repeat (5) cycle(0, 0);

    // Flush with three pending and unit 1 presenting; unit 1 withdraws afterwards.
    present(0, 16'h4444, 3'd4, 4'hc, 2'd0);
    present(2, 16'h5555, 3'd5, 4'hd, 2'd1);
    present(3, 16'h6666, 3'd6, 4'he, 2'd2);
    cycle(0, 0);
    present(1, 16'h7777, 3'd7, 4'hf, 2'd3);
    cycle(0, 1);
    u_on[1] = 1'b0;
    repeat (3) cycle(0, 0);

    // Random traffic with occasional flush and reset.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (!u_on[i] && $urandom_range(0, 99) < 55)
          present(i, 16'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)));
      end
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 49) == 0);
    end

    for (int i = 0; i < N; i++) u_on[i] = 1'b0;
    repeat (8) cycle(0, 0);
    #5;
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
